pix_frame_pack: RTL
===================

PIX_FRAME_PACK -- requirements
Module: pix_frame_pack

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, width of packed pixel word and FIFO data.
REQ-002 SHALL have parameter LEADER_TAG, default 16'h5AA5, upper half of the leader word.
REQ-003 SHALL have parameter TRAILER_TAG, default 8'hA5, top byte of the trailer word.
REQ-004 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_fval  input  1  frame valid from upstream pixel packer.
REQ-007 SHALL have port i_pix_data_en  input  1  packed word valid strobe.
REQ-008 SHALL have port iv_pix_data  input  DATA_WD  packed pixel word.
REQ-009 SHALL have port i_stream_enable  input  1  acquisition enable, sampled only at frame start.
REQ-010 SHALL have port i_fifo_full  input  1  downstream FIFO full.
REQ-011 SHALL have port o_fifo_wr  output  1  FIFO write strobe.
REQ-012 SHALL have port ov_fifo_din  output  DATA_WD  FIFO write data.
REQ-013 SHALL have port ov_frame_cnt  output  16  count of completed frames (trailer written).
REQ-014 SHALL have port o_overflow  output  1  sticky frame-dropped flag.

Function
REQ-015 SHALL register i_fval into fval_dly; frame start = i_fval=1 & fval_dly=0; frame end = i_fval=0 & fval_dly=1.
REQ-016 SHALL implement states IDLE, PAYLOAD, TRAILER, SKIP, DROP.
REQ-017 IDLE, frame start, i_stream_enable=1, i_fifo_full=0: next cycle o_fifo_wr=1, ov_fifo_din={LEADER_TAG, ov_frame_cnt}; clear o_overflow; clear word count; go PAYLOAD.
REQ-018 IDLE, frame start, i_stream_enable=0 or i_fifo_full=1: no write; go SKIP.
REQ-019 SKIP: no writes; on frame end go IDLE.
REQ-020 PAYLOAD, i_fval=1, i_pix_data_en=1, i_fifo_full=0: next cycle o_fifo_wr=1, ov_fifo_din=iv_pix_data (latency 1); word count +1.
REQ-021 PAYLOAD, i_fval=1, i_pix_data_en=1, i_fifo_full=1: word not written; set o_overflow; go DROP.
REQ-022 DROP: no writes, no trailer, ov_frame_cnt unchanged; on frame end go IDLE.
REQ-023 PAYLOAD, frame end: go TRAILER; i_pix_data_en in that cycle ignored (strobe qualified by i_fval=1 only).
REQ-024 TRAILER, i_fifo_full=0: next cycle o_fifo_wr=1, ov_fifo_din={TRAILER_TAG, word_cnt[23:0]}; ov_frame_cnt +1; go IDLE.
REQ-025 TRAILER, i_fifo_full=1: hold state, no write, until not full; a new frame start while waiting is ignored and that frame is treated as SKIP.
REQ-026 Word count SHALL be 24 bits, saturating at 24'hFFFFFF; excludes leader and trailer.
REQ-027 ov_frame_cnt SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 ov_fifo_din SHALL be all zero in cycles with o_fifo_wr=0.
REQ-029 o_fifo_wr SHALL never be high for a cycle in which i_fifo_full was high on the issuing edge.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, o_fifo_wr=0, ov_fifo_din=0, ov_frame_cnt=0, o_overflow=0, word count=0.
REQ-032 fval_dly SHALL reset to 1 so a frame already active at reset release is not captured (no leader until next rising i_fval).
REQ-033 Reset asserted mid-frame SHALL abort the frame with no trailer written.

Verification
REQ-034 Frame: i_fval high 20 cycles, 4 i_pix_data_en words 32'h11223344.. , FIFO never full -> writes: leader 32'h5AA50000, 4 data words each 1 cycle after strobe, trailer 32'hA5000004; ov_frame_cnt=1.
REQ-035 i_fifo_full=1 on 2nd data strobe -> o_overflow=1, only leader+1st word written, no trailer, ov_frame_cnt unchanged; next good frame clears o_overflow and leader carries unchanged count.
REQ-036 i_stream_enable=0 at frame start, toggled to 1 mid-frame -> zero writes for that frame.
REQ-037 i_fifo_full=1 at frame end for 3 cycles -> trailer written on 1st cycle after full drops; no write while full.
REQ-038 Release reset_n with i_fval=1 -> no writes until i_fval falls and rises again; then normal leader.
REQ-039 Preset ov_frame_cnt path to 16'hFFFF via 65535 empty frames (or force) -> next trailer wraps count to 0; next leader = 32'h5AA50000.

Source files
------------

// File: rtl/pix_frame_pack.sv
// -----------------------------------------------------------------------------
// pix_frame_pack
//
// Wraps each frame of packed pixel words from an upstream pixel packer into a
// framed stream for a downstream FIFO:
//
//    leader  : {LEADER_TAG, frame_count}       (written on the frame start edge)
//    payload : one FIFO word per i_pix_data_en (written one cycle later)
//    trailer : {TRAILER_TAG, word_count[23:0]} (written after frame end)
//
// A frame is captured only if acquisition is enabled and the FIFO has room at
// the frame start. If the FIFO is full when a payload word arrives, the rest of
// the frame is dropped (no trailer, frame counter untouched) and the sticky
// overflow flag is raised until the next captured frame.
//
// FIFO write handshake: i_fifo_full is the only back-pressure signal. A word is
// issued on a rising clk edge only if i_fifo_full is low at that edge; the
// issued word appears on ov_fifo_din together with o_fifo_wr=1 for exactly one
// cycle after that edge. ov_fifo_din is all zero whenever o_fifo_wr is low.
//
// Ports
//    clk             in   pixel clock, single clock domain
//    reset_n         in   asynchronous active-low reset
//    i_fval          in   frame valid from the pixel packer
//    i_pix_data_en   in   packed word valid strobe (qualified by i_fval)
//    iv_pix_data     in   packed pixel word [DATA_WD]
//    i_stream_enable in   acquisition enable, sampled at frame start only
//    i_fifo_full     in   downstream FIFO full
//    o_fifo_wr       out  FIFO write strobe (registered)
//    ov_fifo_din     out  FIFO write data [DATA_WD] (registered)
//    ov_frame_cnt    out  number of frames whose trailer was written (wraps)
//    o_overflow      out  sticky "frame dropped" flag
//    dbg_state       out  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module pix_frame_pack #(
   parameter int          DATA_WD     = 32,
   parameter logic [15:0] LEADER_TAG  = 16'h5AA5,
   parameter logic [7:0]  TRAILER_TAG = 8'hA5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_fval,
   input  logic               i_pix_data_en,
   input  logic [DATA_WD-1:0] iv_pix_data,
   input  logic               i_stream_enable,
   input  logic               i_fifo_full,
   output logic               o_fifo_wr,
   output logic [DATA_WD-1:0] ov_fifo_din,
   output logic [15:0]        ov_frame_cnt,
   output logic               o_overflow,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_TRAILER = 3'd2,
      ST_SKIP    = 3'd3,
      ST_DROP    = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic               fval_dly;
   logic               frame_start;
   logic               frame_end;

   logic [23:0]        word_cnt;

   logic               wr_nxt;
   logic [DATA_WD-1:0] din_nxt;
   logic               word_cnt_clr;
   logic               word_cnt_inc;
   logic               frame_cnt_inc;
   logic               overflow_set;
   logic               overflow_clr;

   logic [DATA_WD-1:0] leader_word;
   logic [DATA_WD-1:0] trailer_word;

   // ---------------------------------------------------------------------------
   // Frame edge detection. fval_dly comes out of reset high so that a frame
   // already in progress when reset is released never looks like a start.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fval_dly <= 1'b1;
      end else begin
         fval_dly <= i_fval;
      end
   end

   assign frame_start = i_fval & ~fval_dly;
   assign frame_end   = ~i_fval & fval_dly;

   assign leader_word  = DATA_WD'({LEADER_TAG, ov_frame_cnt});
   assign trailer_word = DATA_WD'({TRAILER_TAG, word_cnt});

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and next-cycle output requests
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      wr_nxt        = 1'b0;
      din_nxt       = '0;
      word_cnt_clr  = 1'b0;
      word_cnt_inc  = 1'b0;
      frame_cnt_inc = 1'b0;
      overflow_set  = 1'b0;
      overflow_clr  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (frame_start) begin
               if (i_stream_enable && !i_fifo_full) begin
                  wr_nxt       = 1'b1;
                  din_nxt      = leader_word;
                  overflow_clr = 1'b1;
                  word_cnt_clr = 1'b1;
                  state_nxt    = ST_PAYLOAD;
               end else begin
                  state_nxt    = ST_SKIP;
               end
            end
         end

         ST_PAYLOAD: begin
            // frame_end implies i_fval low, so a strobe in the end cycle is
            // never taken as payload.
            if (frame_end) begin
               state_nxt = ST_TRAILER;
            end else if (i_fval && i_pix_data_en) begin
               if (i_fifo_full) begin
                  overflow_set = 1'b1;
                  state_nxt    = ST_DROP;
               end else begin
                  wr_nxt       = 1'b1;
                  din_nxt      = iv_pix_data;
                  word_cnt_inc = 1'b1;
               end
            end
         end

         ST_TRAILER: begin
            // Any frame that started while waiting for FIFO room has already
            // lost its leader, so if i_fval is high when the trailer goes out
            // that frame is skipped to its end.
            if (!i_fifo_full) begin
               wr_nxt        = 1'b1;
               din_nxt       = trailer_word;
               frame_cnt_inc = 1'b1;
               state_nxt     = i_fval ? ST_SKIP : ST_IDLE;
            end
         end

         ST_SKIP: begin
            if (frame_end) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_DROP: begin
            if (frame_end) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered FIFO write port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_fifo_wr   <= 1'b0;
         ov_fifo_din <= '0;
      end else begin
         o_fifo_wr   <= wr_nxt;
         ov_fifo_din <= din_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Payload word counter, saturating so a huge frame never reports a small
   // count in its trailer.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt <= '0;
      end else if (word_cnt_clr) begin
         word_cnt <= '0;
      end else if (word_cnt_inc && (word_cnt != 24'hFF_FFFF)) begin
         word_cnt <= word_cnt + 24'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Completed-frame counter (wraps naturally at 16 bits)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ov_frame_cnt <= '0;
      end else if (frame_cnt_inc) begin
         ov_frame_cnt <= ov_frame_cnt + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky overflow flag: raised on a dropped word, cleared only when the next
   // frame is actually captured.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_overflow <= 1'b0;
      end else if (overflow_set) begin
         o_overflow <= 1'b1;
      end else if (overflow_clr) begin
         o_overflow <= 1'b0;
      end
   end

   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // Interface properties
   // ---------------------------------------------------------------------------
   no_wr_when_full : assert property (
      @(posedge clk) disable iff (!reset_n) i_fifo_full |=> !o_fifo_wr);

   din_zero_when_idle : assert property (
      @(posedge clk) disable iff (!reset_n) !o_fifo_wr |-> (ov_fifo_din == '0));

endmodule
